// File: rtl/dense_sigmoid_layer.sv
// -----------------------------------------------------------------------------
// dense_sigmoid_layer
//
// Fully-connected layer of N_OUT neurons over N_IN signed fixed-point inputs.
// Each neuron computes a hard sigmoid of (sum_i x[i]*w[j][i]) + bias[j].
// A single multiplier is shared across all weights: one MAC per cycle, then
// one activation cycle per neuron. Weights and biases live in a runtime
// writable register file that is not touched by reset.
//
// Optional feature macro: DENSE_LAYER_SAT_EN
//   defined   : accumulator saturates at ACC_W limits, z clamps to W range
//   undefined : accumulator wraps, z is the low W bits of acc + bias
//
// Ports:
//   clk       in   clock, all logic on posedge
//   rst       in   synchronous active-high reset (register file retained)
//   req       in   4-phase start request
//   x_flat    in   packed inputs, x[i] = x_flat[i*W +: W]
//   ack       out  result valid / handshake acknowledge
//   y_flat    out  packed activations, y[j] = y_flat[j*W +: W]
//   busy      out  high from accept until return to IDLE
//   cfg_we    in   weight/bias write strobe (honoured only in IDLE)
//   cfg_addr  in   entry j*(N_IN+1)+i, i = N_IN selects the bias of neuron j
//   cfg_data  in   signed value to write
// -----------------------------------------------------------------------------
module dense_sigmoid_layer #(
   parameter int N_IN  = 2,
   parameter int N_OUT = 4,
   parameter int W     = 8,
   parameter int FRAC  = 4,
   parameter int ACC_W = 20,
   localparam int N_ENT = N_OUT * (N_IN + 1),
   localparam int AW    = (N_ENT > 1) ? $clog2(N_ENT) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req,
   input  logic [N_IN*W-1:0]  x_flat,
   output logic               ack,
   output logic [N_OUT*W-1:0] y_flat,
   output logic               busy,
   input  logic               cfg_we,
   input  logic [AW-1:0]      cfg_addr,
   input  logic [W-1:0]       cfg_data
);

   localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic signed [W:0] HALF = (W+1)'(1 << (FRAC - 1));
   localparam logic signed [W:0] ONE  = (W+1)'(1 << FRAC);

   typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

   state_t                    state_q;
   logic [N_IN*W-1:0]         x_q;
   logic signed [ACC_W-1:0]   acc_q;
   logic [IW-1:0]             i_q;
   logic [JW-1:0]             j_q;
   logic [N_OUT*W-1:0]        y_q;
   logic                      ack_q;
   logic                      busy_q;
   logic signed [W-1:0]       rf_q [N_ENT];

   logic [AW-1:0]             wIdx;
   logic [AW-1:0]             bIdx;
   logic signed [W-1:0]       xCur;
   logic signed [W-1:0]       wCur;
   logic signed [W-1:0]       bCur;
   logic signed [2*W-1:0]     prod;
   logic signed [2*W-1:0]     prodSh;
   logic signed [ACC_W-1:0]   pExt;
   logic signed [ACC_W-1:0]   acc_d;
   logic signed [W-1:0]       z;
   logic signed [W:0]         a;
   logic [W-1:0]              act_d;

   // Weight of the current (j,i) pair and bias of the current neuron.
   assign wIdx = AW'(int'(j_q) * (N_IN + 1) + int'(i_q));
   assign bIdx = AW'(int'(j_q) * (N_IN + 1) + N_IN);
   assign xCur = x_q[int'(i_q)*W +: W];
   assign wCur = rf_q[wIdx];
   assign bCur = rf_q[bIdx];

`ifdef DENSE_LAYER_SAT_EN
   localparam logic signed [ACC_W:0] Z_MAX = (ACC_W+1)'((1 << (W - 1)) - 1);
   localparam logic signed [ACC_W:0] Z_MIN = (ACC_W+1)'(-(1 << (W - 1)));
   logic signed [ACC_W:0] sumWide;
   logic signed [ACC_W:0] zWide;
`endif

   // Shared multiplier, product scaling (floor shift), accumulate and the
   // hard-sigmoid of the finished sum. One extra bit of headroom is kept
   // on the saturating adders so overflow can be seen from the top two bits.
   always_comb begin
      prod   = (2*W)'(xCur) * (2*W)'(wCur);
      prodSh = prod >>> FRAC;
      pExt   = ACC_W'(prodSh);
`ifdef DENSE_LAYER_SAT_EN
      sumWide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(pExt);
      if (sumWide[ACC_W] != sumWide[ACC_W-1])
         acc_d = sumWide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
         acc_d = sumWide[ACC_W-1:0];
      zWide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(bCur);
      if (zWide > Z_MAX)
         z = Z_MAX[W-1:0];
      else if (zWide < Z_MIN)
         z = Z_MIN[W-1:0];
      else
         z = zWide[W-1:0];
`else
      acc_d = acc_q + pExt;
      z     = acc_q[W-1:0] + bCur;
`endif
      a = (W+1)'(z >>> 2) + HALF;
      if (a[W])
         act_d = '0;
      else if (a > ONE)
         act_d = ONE[W-1:0];
      else
         act_d = a[W-1:0];
   end

   // Register file: written only while idle, deliberately outside reset so
   // trained weights survive a pipeline reset.
   always_ff @(posedge clk) begin
      if (cfg_we && (state_q == IDLE) && (int'(cfg_addr) < N_ENT))
         rf_q[cfg_addr] <= cfg_data;
   end

   // Sequencer: IDLE accepts a request, MAC walks the inputs of neuron j,
   // ACT writes y[j], DONE holds ack until the requester drops req.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         acc_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         y_q     <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  x_q     <= x_flat;
                  acc_q   <= '0;
                  i_q     <= '0;
                  j_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= MAC;
               end
            end
            MAC: begin
               acc_q <= acc_d;
               if (int'(i_q) == N_IN - 1)
                  state_q <= ACT;
               else
                  i_q <= i_q + 1'b1;
            end
            ACT: begin
               y_q[int'(j_q)*W +: W] <= act_d;
               acc_q <= '0;
               i_q   <= '0;
               if (int'(j_q) == N_OUT - 1) begin
                  ack_q   <= 1'b1;
                  state_q <= DONE;
               end else begin
                  j_q     <= j_q + 1'b1;
                  state_q <= MAC;
               end
            end
            DONE: begin
               if (!req) begin
                  ack_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack    = ack_q;
   assign busy   = busy_q;
   assign y_flat = y_q;

endmodule

// File: tb/tb_dense_sigmoid_layer.sv
// -----------------------------------------------------------------------------
// tb_dense_sigmoid_layer
//
// Directed bench for dense_sigmoid_layer. Instance dut uses the default
// parameters (N_IN=2, N_OUT=4); instance dut1 uses N_OUT=1 for the single
// neuron example. Expected activations are hand-computed constants; entries
// that depend on DENSE_LAYER_SAT_EN are selected with the same macro.
// -----------------------------------------------------------------------------
module tb_dense_sigmoid_layer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        req = 1'b0;
   logic [15:0] xFlat = '0;
   logic        ack;
   logic [31:0] yFlat;
   logic        busy;
   logic        cfgWe = 1'b0;
   logic [3:0]  cfgAddr = '0;
   logic [7:0]  cfgData = '0;

   logic        req1 = 1'b0;
   logic [15:0] xFlat1 = '0;
   logic        ack1;
   logic [7:0]  yFlat1;
   logic        busy1;
   logic        cfgWe1 = 1'b0;
   logic [1:0]  cfgAddr1 = '0;
   logic [7:0]  cfgData1 = '0;

   int nAsserts = 0;
   int nFails   = 0;
   int lat;

`ifdef DENSE_LAYER_SAT_EN
   localparam logic [7:0] Y0A = 8'd16;
   localparam logic [7:0] Y0B = 8'd16;
   localparam logic [7:0] Y1C = 8'd16;
`else
   localparam logic [7:0] Y0A = 8'd0;
   localparam logic [7:0] Y0B = 8'd7;
   localparam logic [7:0] Y1C = 8'd0;
`endif

   dense_sigmoid_layer dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .x_flat   (xFlat),
      .ack      (ack),
      .y_flat   (yFlat),
      .busy     (busy),
      .cfg_we   (cfgWe),
      .cfg_addr (cfgAddr),
      .cfg_data (cfgData)
   );

   dense_sigmoid_layer #(.N_IN(2), .N_OUT(1)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .req      (req1),
      .x_flat   (xFlat1),
      .ack      (ack1),
      .y_flat   (yFlat1),
      .busy     (busy1),
      .cfg_we   (cfgWe1),
      .cfg_addr (cfgAddr1),
      .cfg_data (cfgData1)
   );

   always #5 clk = ~clk;

   // Advance one posedge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Single register-file write on the default instance.
   task automatic applyStimulus(input int addr, input int data);
      cfgWe   = 1'b1;
      cfgAddr = 4'(addr);
      cfgData = 8'(data);
      tick();
      cfgWe   = 1'b0;
   endtask

   // Accept an operation, optionally drop req right away, and count edges
   // after the accept edge until ack shows up (bounded).
   task automatic runOp(input logic [15:0] xv, input bit dropEarly, output int edges);
      req   = 1'b1;
      xFlat = xv;
      tick();
      checkOutput("busyAfterAccept", 32'(busy), 32'd1);
      if (dropEarly) req = 1'b0;
      edges = 0;
      while (ack !== 1'b1 && edges < 40) begin
         tick();
         edges++;
      end
   endtask

   task automatic releaseReq(input string tag);
      req = 1'b0;
      tick();
      checkOutput({tag, "_ackLow"}, 32'(ack), 32'd0);
      checkOutput({tag, "_busyLow"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state
      tick();
      tick();
      checkOutput("rst_ack", 32'(ack), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_y", yFlat, 32'd0);
      checkOutput("rst_ack1", 32'(ack1), 32'd0);
      rst = 1'b0;
      tick();

      // All weights and biases zero: every neuron gives 0.5
      for (int k = 0; k < 12; k++) applyStimulus(k, 0);
      runOp({8'hFB, 8'd37}, 1'b0, lat);
      checkOutput("zero_latency", 32'(lat), 32'd12);
      checkOutput("zero_y", yFlat, 32'h08080808);
      tick();
      tick();
      checkOutput("zero_ackHeld", 32'(ack), 32'd1);
      checkOutput("zero_busyHeld", 32'(busy), 32'd1);
      releaseReq("zero");
      checkOutput("zero_yHold", yFlat, 32'h08080808);

      // Neuron weights: n0 [127,127] b0; n1 [-52,48] b-11; n2 [1,2] b-1; n3 zero
      applyStimulus(0, 127);
      applyStimulus(1, 127);
      applyStimulus(2, 0);
      applyStimulus(3, -52);
      applyStimulus(4, 48);
      applyStimulus(5, -11);
      applyStimulus(6, 1);
      applyStimulus(7, 2);
      applyStimulus(8, -1);

      // x = [127,127]: n0 z=2016 (sat 16 / wrap 0), n1 0, n2 13, n3 8
      runOp(16'h7F7F, 1'b0, lat);
      checkOutput("big_latency", 32'(lat), 32'd12);
      checkOutput("big_y", yFlat, {8'd8, 8'd13, 8'd0, Y0A});
      releaseReq("big");

      // x = [1.0,1.0]: n0 z=254 (sat 16 / wrap 7), n1 4, n2 8, n3 8
      runOp(16'h1010, 1'b0, lat);
      checkOutput("one_latency", 32'(lat), 32'd12);
      checkOutput("one_y", yFlat, {8'd8, 8'd8, 8'd4, Y0B});
      releaseReq("one");

      // x = [-16,32]: n0 16, n1 z=137 (sat 16 / wrap 0), n2 8, n3 8
      runOp(16'h20F0, 1'b0, lat);
      checkOutput("mix_y", yFlat, {8'd8, 8'd8, Y1C, 8'd16});
      releaseReq("mix");

      // x = [-1,0]: floor of negative products, y = 6,6,7,8
      runOp(16'h00FF, 1'b0, lat);
      checkOutput("neg_y", yFlat, 32'h08070606);
      releaseReq("neg");

      // Reset during the second neuron's MAC, then rerun unbroken
      req   = 1'b1;
      xFlat = 16'h00FF;
      tick();
      req = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      checkOutput("midRst_ack", 32'(ack), 32'd0);
      checkOutput("midRst_busy", 32'(busy), 32'd0);
      checkOutput("midRst_y", yFlat, 32'd0);
      rst = 1'b0;
      runOp(16'h00FF, 1'b0, lat);
      checkOutput("rerun_latency", 32'(lat), 32'd12);
      checkOutput("rerun_y", yFlat, 32'h08070606);
      releaseReq("rerun");

      // Weight writes while busy are ignored
      req   = 1'b1;
      xFlat = 16'h1010;
      tick();
      cfgWe   = 1'b1;
      cfgAddr = 4'd9;
      cfgData = 8'd100;
      tick();
      tick();
      tick();
      cfgWe = 1'b0;
      lat = 3;
      while (ack !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      checkOutput("busyWr_latency", 32'(lat), 32'd12);
      checkOutput("busyWr_y", yFlat, {8'd8, 8'd8, 8'd4, Y0B});
      releaseReq("busyWr");

      // Write in the accept cycle is visible: n3 w0=100 gives y3=16
      cfgWe   = 1'b1;
      cfgAddr = 4'd9;
      cfgData = 8'd100;
      req     = 1'b1;
      xFlat   = 16'h1010;
      tick();
      cfgWe = 1'b0;
      lat = 0;
      while (ack !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      checkOutput("acceptWr_latency", 32'(lat), 32'd12);
      checkOutput("acceptWr_y", yFlat, {8'd16, 8'd8, 8'd4, Y0B});
      releaseReq("acceptWr");

      // req dropped right after accept: completes, ack is a 1-cycle pulse
      runOp(16'h00FF, 1'b1, lat);
      checkOutput("early_latency", 32'(lat), 32'd12);
      checkOutput("early_y", yFlat, 32'h06070606);
      tick();
      checkOutput("early_ackPulse", 32'(ack), 32'd0);
      checkOutput("early_busyLow", 32'(busy), 32'd0);

      // Single-neuron instance: w=[-52,48], bias=-11, x=[16,16] -> y0=4 at edge 3
      cfgWe1 = 1'b1;
      cfgAddr1 = 2'd0; cfgData1 = 8'hCC; tick();
      cfgAddr1 = 2'd1; cfgData1 = 8'd48;  tick();
      cfgAddr1 = 2'd2; cfgData1 = 8'hF5; tick();
      cfgWe1 = 1'b0;
      req1   = 1'b1;
      xFlat1 = 16'h1010;
      tick();
      checkOutput("n1_busy", 32'(busy1), 32'd1);
      lat = 0;
      while (ack1 !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      checkOutput("n1_latency", 32'(lat), 32'd3);
      checkOutput("n1_y", 32'(yFlat1), 32'd4);
      req1 = 1'b0;
      tick();
      checkOutput("n1_ackLow", 32'(ack1), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule

// File: doc/dense_sigmoid_layer.md
# dense_sigmoid_layer

Parametrised fully-connected neural-network layer: N_IN signed fixed-point inputs, N_OUT neurons, each computing a hard-sigmoid of a weighted sum plus bias. A single shared multiplier is time-multiplexed over all weights. Weights and biases sit in a runtime-loadable register file. The block is a drop-in successor to the fixed single-neuron sigmoid layer in the network pipeline and chains layer-to-layer through a 4-phase req/ack handshake.

## Interface
- N_IN, 2, inputs per neuron (≥1)
- N_OUT, 4, neurons (≥1)
- W, 8, data/weight width, signed two's complement
- FRAC, 4, fraction bits (1.0 = 1<<FRAC)
- ACC_W, 20, accumulator width (≥ W+FRAC+clog2(N_IN)+1)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- req  in  1  start request, level, 4-phase
- x_flat  in  N_IN*W  inputs; x[i] = x_flat[i*W +: W]
- ack  out  1  result valid / handshake acknowledge
- y_flat  out  N_OUT*W  activations; y[j] = y_flat[j*W +: W]
- busy  out  1  high from accept until return to IDLE
- cfg_we  in  1  weight/bias write strobe
- cfg_addr  in  clog2(N_OUT*(N_IN+1))  entry j*(N_IN+1)+i; i=N_IN is bias of neuron j
- cfg_data  in  W  signed value written

## Operation
- FSM states: IDLE, MAC, ACT, DONE.
- IDLE: on req=1, capture x_flat into an internal register, clear acc, set j=0 and i=0, then go to MAC.
- MAC: each cycle compute p = (x[i]*w[j][i]) >>> FRAC (2W-bit signed product, arithmetic shift, floor), sign-extend it, and add to acc. After i=N_IN-1, go to ACT.
- ACT: z = acc + bias[j] (sign-extended), reduced to W bits, then hard sigmoid: a = (z >>> 2) + (1<<(FRAC-1)), clipped to [0, 1<<FRAC]. Write y[j] = a, clear acc, set i=0. If j=N_OUT-1 go to DONE, else j++ and return to MAC.
- DONE: ack=1. Stay until req=0, then go to IDLE with ack=0 on the next edge.
- y holds its value from the end of one computation until the next ACT write for that index.
- cfg writes are accepted only in IDLE and ignored while busy=1. Register-file contents survive rst; its power-up value is 0.
- Once accepted, an operation completes even if req drops early. DONE then sees req=0 and ack is a 1-cycle pulse.
- rst at any time: go to IDLE, ack=0, busy=0, y_flat=0, acc=0. Weights are retained.
- Reset values: ack=0, busy=0, y_flat=0.

## Timing
- Accept edge = the posedge on which IDLE samples req=1. busy rises on that edge.
- Each neuron takes N_IN MAC cycles plus 1 ACT cycle.
- ack rises N_OUT*(N_IN+1) edges after the accept edge. Default parameters: 12 cycles.
- ack falls on the first edge sampling req=0 in DONE. busy falls on the same edge.
- The earliest re-accept is the edge after the return to IDLE, so back-to-back throughput is one operation per N_OUT*(N_IN+1)+2 cycles.
- A cfg_we in the same cycle as an accepted req is applied, and is visible to the operation being started.

## Configuration
- DENSE_LAYER_SAT_EN defined:
  - accumulator adds saturate at the ACC_W signed limits
  - z is clamped to [-(2^(W-1)), 2^(W-1)-1] before activation
- DENSE_LAYER_SAT_EN undefined:
  - accumulator wraps modulo 2^ACC_W
  - z is truncated to its low W bits (legacy wrap behaviour)
  - saturation logic is absent from the netlist

## Test plan
- W=8, FRAC=4, N_IN=2, N_OUT=1; w=[-52,48], bias=-11; x=[16,16]. Expect acc=-4, z=-15, y0=4, ack on edge 3 after accept.
- Default parameters, all weights 0, all biases 0, any x. Expect every y=8 (0.5); ack held until req drops, falls the following edge.
- N_IN=2, w=[127,127], bias=0, x=[127,127]. Expect z=2016: with DENSE_LAYER_SAT_EN y0=16; without it z truncates to -32 and y0=0.
- Assert rst mid-MAC (cycle 3 after accept). Expect ack=0, busy=0, y_flat=0 next edge. A re-run with the same x gives results identical to an unbroken run.
- cfg_we pulses while busy=1 (new weight 100). Expect the current result unchanged. After DONE→IDLE, write and rerun: the result reflects weight 100.
- req dropped one cycle after accept. Expect the operation to complete, ack high for exactly 1 cycle, and return to IDLE.
